// File: rtl/psx_controller_emu.sv
// PSX pad emulator: oversamples the console link on the board clock and answers
// poll frames as a digital (ID 0x41) or analog (ID 0x73) pad with timed ack pulses.
module psx_controller_emu #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_DELAY   = 3,
  parameter int unsigned ACK_WIDTH   = 1,
  parameter logic [7:0]  ADDR_BYTE   = 8'h01,
  parameter logic [7:0]  CMD_POLL    = 8'h42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psx_clk,
  input  logic        att,
  input  logic        cmd,
  input  logic [15:0] buttons,
  input  logic [31:0] sticks,
  input  logic        analog_en,
  output logic        data,
  output logic        ack,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT    = 3'd1,
    ST_ACK_WAIT = 3'd2,
    ST_ACK_LOW  = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

  localparam logic [7:0] ACK_DELAY_LAST = 8'(ACK_DELAY - 1);
  localparam logic [7:0] ACK_WIDTH_LAST = 8'(ACK_WIDTH - 1);

  logic [SYNC_STAGES-1:0] clk_sync_r, att_sync_r, cmd_sync_r;
  logic                   clk_prev_r, att_prev_r;
  logic                   clk_s, att_s, cmd_s;
  logic                   clk_rise_s, clk_fall_s, att_rise_s, att_fall_s;

  state_t      state_r, state_n;
  logic [3:0]  byte_idx_r;
  logic [2:0]  bit_idx_r;
  logic [6:0]  rx_r;
  logic [7:0]  tx_r;
  logic [7:0]  cnt_r;
  logic [15:0] btn_r;
  logic [31:0] stk_r;
  logic        analog_r;
  logic        data_r, ack_r, busy_r, done_r;
  logic        data_n, ack_n, busy_n, done_n;

  logic [7:0]  rx_byte_s;
  logic [3:0]  last_idx_s;
  logic        byte_done_s, reject_s, last_s;

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [15:0] btn,
                                            input logic [31:0] stk, input logic an);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hFF;
      4'd1:    b = an ? 8'h73 : 8'h41;
      4'd2:    b = 8'h5A;
      4'd3:    b = btn[7:0];
      4'd4:    b = btn[15:8];
      4'd5:    b = stk[7:0];
      4'd6:    b = stk[15:8];
      4'd7:    b = stk[23:16];
      4'd8:    b = stk[31:24];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign clk_s      = clk_sync_r[SYNC_STAGES-1];
  assign att_s      = att_sync_r[SYNC_STAGES-1];
  assign cmd_s      = cmd_sync_r[SYNC_STAGES-1];
  assign clk_rise_s = clk_s & ~clk_prev_r;
  assign clk_fall_s = ~clk_s & clk_prev_r;
  assign att_rise_s = att_s & ~att_prev_r;
  assign att_fall_s = ~att_s & att_prev_r;

  // rx_r holds bits 0..6 of the current byte; bit 7 arrives with the completing edge
  assign rx_byte_s   = {cmd_s, rx_r};
  assign last_idx_s  = analog_r ? 4'd8 : 4'd4;
  assign byte_done_s = clk_rise_s & (bit_idx_r == 3'd7);
  assign reject_s    = ((byte_idx_r == 4'd0) && (rx_byte_s != ADDR_BYTE)) ||
                       ((byte_idx_r == 4'd1) && (rx_byte_s != CMD_POLL));
  assign last_s      = (byte_idx_r == last_idx_s);

  // att chain resets low so a frame already running at reset release is not taken as new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r <= '1;
      att_sync_r <= '0;
      cmd_sync_r <= '1;
      clk_prev_r <= 1'b1;
      att_prev_r <= 1'b0;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], psx_clk};
      att_sync_r <= {att_sync_r[SYNC_STAGES-2:0], att};
      cmd_sync_r <= {cmd_sync_r[SYNC_STAGES-2:0], cmd};
      clk_prev_r <= clk_s;
      att_prev_r <= att_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      data_r  <= 1'b1;
      ack_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      data_r  <= data_n;
      ack_r   <= ack_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
    end
  end

  // Next-state decode; att rise takes priority over any psx_clk edge
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (att_fall_s) state_n = ST_SHIFT;
        else            state_n = ST_IDLE;
      end
      ST_SHIFT: begin
        if (att_rise_s)                        state_n = ST_IDLE;
        else if (byte_done_s && (reject_s || last_s)) state_n = ST_HOLD;
        else if (byte_done_s)                  state_n = ST_ACK_WAIT;
        else                                   state_n = ST_SHIFT;
      end
      ST_ACK_WAIT: begin
        if (att_rise_s)                    state_n = ST_IDLE;
        else if (clk_fall_s)               state_n = ST_SHIFT;
        else if (cnt_r == ACK_DELAY_LAST)  state_n = ST_ACK_LOW;
        else                               state_n = ST_ACK_WAIT;
      end
      ST_ACK_LOW: begin
        if (att_rise_s)                                  state_n = ST_IDLE;
        else if (clk_fall_s || (cnt_r == ACK_WIDTH_LAST)) state_n = ST_SHIFT;
        else                                             state_n = ST_ACK_LOW;
      end
      ST_HOLD: begin
        if (att_rise_s) state_n = ST_IDLE;
        else            state_n = ST_HOLD;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    data_n = data_r;
    ack_n  = ack_r;
    busy_n = busy_r;
    done_n = 1'b0;
    case (state_r)
      ST_IDLE: begin
        data_n = 1'b1;
        ack_n  = 1'b1;
        if (att_fall_s) busy_n = 1'b1;
        else            busy_n = 1'b0;
      end
      ST_SHIFT: begin
        if (att_rise_s) begin
          data_n = 1'b1;
          ack_n  = 1'b1;
          busy_n = 1'b0;
        end else if (byte_done_s) begin
          if (reject_s || last_s) data_n = 1'b1;
          else                    data_n = data_r;
          done_n = ~reject_s & last_s;
        end else if (clk_fall_s) begin
          data_n = tx_r[bit_idx_r];
        end else begin
          data_n = data_r;
        end
      end
      ST_ACK_WAIT, ST_ACK_LOW: begin
        if (att_rise_s) begin
          data_n = 1'b1;
          ack_n  = 1'b1;
          busy_n = 1'b0;
        end else if (clk_fall_s) begin
          ack_n  = 1'b1;
          data_n = tx_r[bit_idx_r];
        end else if (state_n == ST_ACK_LOW) begin
          ack_n = 1'b0;
        end else begin
          ack_n = 1'b1;
        end
      end
      ST_HOLD: begin
        data_n = 1'b1;
        ack_n  = 1'b1;
        if (att_rise_s) busy_n = 1'b0;
        else            busy_n = 1'b1;
      end
      default: begin
        data_n = 1'b1;
        ack_n  = 1'b1;
        busy_n = 1'b0;
      end
    endcase
  end

  // Frame datapath: input snapshot, byte/bit indices, shift registers, ack timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      rx_r       <= 7'd0;
      tx_r       <= 8'hFF;
      cnt_r      <= 8'd0;
      btn_r      <= 16'hFFFF;
      stk_r      <= 32'd0;
      analog_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (att_fall_s) begin
            btn_r      <= buttons;
            stk_r      <= sticks;
            analog_r   <= analog_en;
            byte_idx_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            rx_r       <= 7'd0;
            tx_r       <= 8'hFF;
          end
        end
        ST_SHIFT: begin
          if (clk_rise_s && !att_rise_s) begin
            rx_r      <= {cmd_s, rx_r[6:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (byte_done_s && !reject_s && !last_s) begin
              byte_idx_r <= byte_idx_r + 4'd1;
              tx_r       <= frame_byte(byte_idx_r + 4'd1, btn_r, stk_r, analog_r);
            end
          end
        end
        default: begin
        end
      endcase
      if (state_n != state_r)
        cnt_r <= 8'd0;
      else if ((state_r == ST_ACK_WAIT) || (state_r == ST_ACK_LOW))
        cnt_r <= cnt_r + 8'd1;
      else
        cnt_r <= 8'd0;
    end
  end

  assign data       = data_r;
  assign ack        = ack_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_psx_controller_emu.sv
// Bench for psx_controller_emu: a console model drives the link, a scoreboard queue holds
// the expected pad bytes and independent monitors check bytes, ack timing and frame_done.
module tb_psx_controller_emu;
  localparam int SYNC_STAGES = 2;
  localparam int ACK_DELAY   = 3;
  localparam int ACK_WIDTH   = 1;
  localparam int ACK_LAT     = SYNC_STAGES + 1 + ACK_DELAY;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psx_clk = 1'b1;
  logic        att = 1'b1;
  logic        cmd = 1'b1;
  logic [15:0] buttons = 16'hFFFF;
  logic [31:0] sticks = 32'd0;
  logic        analog_en = 1'b0;
  logic        data, ack, busy, frame_done;

  psx_controller_emu #(
    .SYNC_STAGES(SYNC_STAGES), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH),
    .ADDR_BYTE(8'h01), .CMD_POLL(8'h42)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psx_clk(psx_clk), .att(att), .cmd(cmd),
    .buttons(buttons), .sticks(sticks), .analog_en(analog_en),
    .data(data), .ack(ack), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int ack_low = 0;
  int mon_bits = 0;
  logic       ack_prev = 1'b1;
  logic [7:0] mon_sh = 8'd0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte monitor: console samples pad data on psx_clk rise while selected
  always @(negedge att) mon_bits = 0;
  always @(posedge psx_clk) begin
    if (!att) begin
      mon_sh[mon_bits[2:0]] = data;
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_byte: got %02h, expected no byte", mon_sh);
        end else begin
          check("rx_byte", 32'(mon_sh), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Ack/frame_done monitor sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_done === 1'b1) done_cnt++;
      if (!ack && ack_prev) begin
        ack_cnt++;
        ack_low = 1;
        check("ack_latency", 32'(cyc - last_rise_cyc), 32'(ACK_LAT));
      end else if (!ack) begin
        ack_low++;
      end else if (ack && !ack_prev) begin
        check("ack_width", 32'(ack_low), 32'(ACK_WIDTH));
      end
      ack_prev = ack;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      psx_clk = 1'b0;
      cmd = b[i];
      tick(half);
      psx_clk = 1'b1;
      last_rise_cyc = cyc;
      tick(half);
    end
  endtask

  // Full frame: bytes are packed LSB-first (byte 0 in [7:0])
  task automatic frame(input int n, input logic [71:0] c, input logic [71:0] e,
                       input int half, input int gap);
    for (int i = 0; i < n; i++) exp_q.push_back(e[8*i +: 8]);
    att = 1'b0;
    tick(8);
    for (int i = 0; i < n; i++) begin
      send_bits(c[8*i +: 8], 8, half);
      tick(gap);
    end
    tick(6);
    att = 1'b1;
    tick(10);
  endtask

  int a0, d0;

  initial begin
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("reset_data", 32'(data), 32'd1);
    check("reset_ack", 32'(ack), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);

    // 1: digital poll
    buttons = 16'hFF7F; analog_en = 1'b0;
    a0 = ack_cnt; d0 = done_cnt;
    frame(5, 72'h00_0000_0000_0000_4201, 72'h00_0000_00FF_7F5A_41FF, 8, 12);
    check("dig_acks", 32'(ack_cnt - a0), 32'd4);
    check("dig_done", 32'(done_cnt - d0), 32'd1);
    check("dig_busy_end", 32'(busy), 32'd0);

    // 2: analog poll
    buttons = 16'hA5C3; sticks = 32'h807F10F0; analog_en = 1'b1;
    a0 = ack_cnt; d0 = done_cnt;
    frame(9, 72'h00_0000_0000_0000_4201, 72'h80_7F10_F0A5_C35A_73FF, 8, 12);
    check("ana_acks", 32'(ack_cnt - a0), 32'd8);
    check("ana_done", 32'(done_cnt - d0), 32'd1);

    // 3: wrong address
    analog_en = 1'b0; buttons = 16'h0000;
    a0 = ack_cnt; d0 = done_cnt;
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    att = 1'b0;
    tick(8);
    send_bits(8'h81, 8, 8);
    tick(12);
    send_bits(8'h42, 8, 8);
    tick(6);
    check("noaddr_busy", 32'(busy), 32'd1);
    check("noaddr_data", 32'(data), 32'd1);
    check("noaddr_acks", 32'(ack_cnt - a0), 32'd0);
    check("noaddr_done", 32'(done_cnt - d0), 32'd0);
    att = 1'b1;
    tick(SYNC_STAGES + 1);
    check("noaddr_busy_rel", 32'(busy), 32'd0);
    tick(10);

    // 4: att rises after 3 bits of byte 2 (pad is driving a 0 at that point)
    buttons = 16'hFFFF;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h41);
    att = 1'b0;
    tick(8);
    send_bits(8'h01, 8, 8);
    tick(12);
    send_bits(8'h42, 8, 8);
    tick(12);
    send_bits(8'h00, 3, 8);
    check("abort_data_before", 32'(data), 32'd0);
    att = 1'b1;
    tick(SYNC_STAGES + 1);
    check("abort_data", 32'(data), 32'd1);
    check("abort_ack", 32'(ack), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    tick(10);
    buttons = 16'h5AA5;
    frame(5, 72'h00_0000_0000_0000_4201, 72'h00_0000_005A_A55A_41FF, 8, 12);

    // 5: minimum inter-byte gap, psx_clk falls as the ack ends
    buttons = 16'h3C81;
    a0 = ack_cnt;
    frame(5, 72'h00_0000_0000_0000_4201, 72'h00_0000_003C_815A_41FF, 4, 0);
    check("fast_acks", 32'(ack_cnt - a0), 32'd4);

    // 6a: buttons change mid-frame
    buttons = 16'h1234;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h41); exp_q.push_back(8'h5A);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    att = 1'b0;
    tick(8);
    send_bits(8'h01, 8, 8);
    tick(12);
    send_bits(8'h42, 8, 8);
    tick(12);
    buttons = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      send_bits(8'h00, 8, 8);
      tick(12);
    end
    att = 1'b1;
    tick(10);

    // 6b: reset pulse mid-frame, then no restart while att stays low
    buttons = 16'hFF00;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h41); exp_q.push_back(8'h5A);
    att = 1'b0;
    tick(8);
    send_bits(8'h01, 8, 8);
    tick(12);
    send_bits(8'h42, 8, 8);
    tick(12);
    send_bits(8'h00, 8, 8);
    tick(12);
    send_bits(8'h00, 4, 8);
    check("prerst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_data", 32'(data), 32'd1);
    check("rst_ack", 32'(ack), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    tick(2);
    rst_n = 1'b1;
    ack_prev = 1'b1;
    tick(10);
    check("rst_no_restart", 32'(busy), 32'd0);
    att = 1'b1;
    tick(10);
    frame(5, 72'h00_0000_0000_0000_4201, 72'h00_0000_00FF_005A_41FF, 8, 12);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
